// File: rtl/melody_round_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : melody_round_sequencer
// Description : Melody memory game controller. Plays back the first L notes
//               of a stored 8-note melody, then judges the player's keys,
//               growing L from 3 to 8 and counting misses to a lose state.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module melody_round_sequencer #(
  parameter int NOTE_TICKS    = 3,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int MAX_MISSES    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seq_load,
  input  logic [31:0] seq_data,
  input  logic        start,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  note_out,
  output logic        note_valid,
  output logic [2:0]  state_out,
  output logic [3:0]  length_out,
  output logic [2:0]  index_out,
  output logic [1:0]  miss_count,
  output logic        round_pass,
  output logic        round_fail,
  output logic        game_win,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_LISTEN   = 3'd3,
    S_PASS     = 3'd4,
    S_FAIL     = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  // Counters compare against "last tick" so that a count of N spans N cycles.
  localparam logic [7:0]  NOTE_LAST    = 8'(NOTE_TICKS - 1);
  localparam logic [7:0]  GAP_LAST     = 8'(GAP_TICKS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [1:0]  MISS_LIMIT   = 2'(MAX_MISSES);

  state_t      state, state_nx;
  logic [31:0] melody, melody_nx;
  logic        loaded, loaded_nx;
  logic [7:0]  tick, tick_nx;
  logic [15:0] timer, timer_nx;
  logic [3:0]  length_nx;
  logic [2:0]  index_nx;
  logic [1:0]  miss_nx;
  logic [3:0]  note_nx;
  logic        valid_nx;
  logic        pass_nx, fail_nx, win_nx, over_nx;
  logic        at_last;
  logic        idle_like;

  function automatic logic [3:0] note_at(input logic [31:0] mel, input logic [2:0] idx);
    logic [31:0] sh;
    sh = mel >> {idx, 2'b00};
    return sh[3:0];
  endfunction

  assign state_out = state;
  assign at_last   = ({1'b0, index_out} == (length_out - 4'd1));
  assign idle_like = (state == S_IDLE) || (state == S_WIN) || (state == S_LOSE);

  // Next-state and next-output computation for every registered signal.
  always_comb begin
    state_nx  = state;
    melody_nx = melody;
    loaded_nx = loaded;
    tick_nx   = tick;
    timer_nx  = timer;
    length_nx = length_out;
    index_nx  = index_out;
    miss_nx   = miss_count;
    note_nx   = note_out;
    valid_nx  = note_valid;
    pass_nx   = 1'b0;
    fail_nx   = 1'b0;
    win_nx    = game_win;
    over_nx   = game_over;

    if (idle_like) begin
      if (seq_load) begin
        melody_nx = seq_data;
        loaded_nx = 1'b1;
      end
      // A same-cycle load counts as loaded and its data is what gets played.
      if (start && (loaded || seq_load)) begin
        state_nx  = S_PLAY_ON;
        length_nx = 4'd3;
        index_nx  = 3'd0;
        miss_nx   = 2'd0;
        win_nx    = 1'b0;
        over_nx   = 1'b0;
        tick_nx   = 8'd0;
        note_nx   = note_at(melody_nx, 3'd0);
        valid_nx  = 1'b1;
      end
    end

    case (state)
      S_PLAY_ON: begin
        if (tick == NOTE_LAST) begin
          state_nx = S_PLAY_OFF;
          tick_nx  = 8'd0;
          note_nx  = 4'd0;
          valid_nx = 1'b0;
        end else begin
          tick_nx = tick + 8'd1;
        end
      end
      S_PLAY_OFF: begin
        if (tick == GAP_LAST) begin
          tick_nx = 8'd0;
          if (at_last) begin
            state_nx = S_LISTEN;
            index_nx = 3'd0;
            timer_nx = 16'd0;
          end else begin
            state_nx = S_PLAY_ON;
            index_nx = index_out + 3'd1;
            note_nx  = note_at(melody, index_out + 3'd1);
            valid_nx = 1'b1;
          end
        end else begin
          tick_nx = tick + 8'd1;
        end
      end
      S_LISTEN: begin
        // A key in the expiry cycle is judged instead of timing out.
        if (key_valid) begin
          timer_nx = 16'd0;
          if (key_code == note_at(melody, index_out)) begin
            if (at_last) begin
              state_nx = S_PASS;
              pass_nx  = 1'b1;
            end else begin
              index_nx = index_out + 3'd1;
            end
          end else begin
            state_nx = S_FAIL;
            fail_nx  = 1'b1;
            miss_nx  = (miss_count == 2'd3) ? miss_count : miss_count + 2'd1;
          end
        end else if (timer == TIMEOUT_LAST) begin
          state_nx = S_FAIL;
          fail_nx  = 1'b1;
          miss_nx  = (miss_count == 2'd3) ? miss_count : miss_count + 2'd1;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      S_PASS: begin
        if (length_out == 4'd8) begin
          state_nx = S_WIN;
          win_nx   = 1'b1;
        end else begin
          state_nx  = S_PLAY_ON;
          length_nx = length_out + 4'd1;
          index_nx  = 3'd0;
          tick_nx   = 8'd0;
          note_nx   = note_at(melody, 3'd0);
          valid_nx  = 1'b1;
        end
      end
      S_FAIL: begin
        index_nx = 3'd0;
        if (miss_count == MISS_LIMIT) begin
          state_nx = S_LOSE;
          over_nx  = 1'b1;
        end else begin
          state_nx = S_PLAY_ON;
          tick_nx  = 8'd0;
          note_nx  = note_at(melody, 3'd0);
          valid_nx = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      melody     <= 32'd0;
      loaded     <= 1'b0;
      tick       <= 8'd0;
      timer      <= 16'd0;
      length_out <= 4'd3;
      index_out  <= 3'd0;
      miss_count <= 2'd0;
      note_out   <= 4'd0;
      note_valid <= 1'b0;
      round_pass <= 1'b0;
      round_fail <= 1'b0;
      game_win   <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nx;
      melody     <= melody_nx;
      loaded     <= loaded_nx;
      tick       <= tick_nx;
      timer      <= timer_nx;
      length_out <= length_nx;
      index_out  <= index_nx;
      miss_count <= miss_nx;
      note_out   <= note_nx;
      note_valid <= valid_nx;
      round_pass <= pass_nx;
      round_fail <= fail_nx;
      game_win   <= win_nx;
      game_over  <= over_nx;
    end
  end

endmodule
`default_nettype wire

// File: doc/melody_round_sequencer.md
# melody_round_sequencer

Game-flow controller for the melody memory game. Stores a 32-bit melody (eight 4-bit notes), sequences the automatic playback of the first L notes to the piezo/LED drivers, then listens for the player's key strobes and judges them. It grows L from 3 to 8 on each cleared round and counts misses to a lose condition. It sits between the host/data loader and the piezo/LED output stage and replaces ad-hoc playback sequencing.

## Interface
Parameters:
- NOTE_TICKS, 3, cycles a note is driven (legal 1..255)
- GAP_TICKS, 1, silent cycles after each note (legal 1..255)
- TIMEOUT_TICKS, 1000, idle cycles in LISTEN before a miss (legal 1..65535)
- MAX_MISSES, 3, misses that end the game (legal 1..3)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- seq_load  in  1  capture seq_data; note k = seq_data[4k+3:4k]
- seq_data  in  32  melody
- start  in  1  begin or restart a game
- key_valid  in  1  one-cycle strobe, player key press
- key_code  in  4  note pressed
- note_out  out  4  note to piezo/LED; 0 when silent
- note_valid  out  1  high while a note is driven
- state_out  out  3  IDLE=0 PLAY_ON=1 PLAY_OFF=2 LISTEN=3 PASS=4 FAIL=5 WIN=6 LOSE=7
- length_out  out  4  current round length, 3..8
- index_out  out  3  current note index
- miss_count  out  2  misses so far
- round_pass  out  1  one-cycle pulse, round cleared
- round_fail  out  1  one-cycle pulse, miss recorded
- game_win  out  1  level, high in WIN
- game_over  out  1  level, high in LOSE

## Operation
- All outputs registered. Reset values: state IDLE, note_out 0, note_valid 0, length_out 3, index_out 0, miss_count 0, all pulses/levels 0; melody register and internal "loaded" flag cleared.
- seq_load accepted only in IDLE, WIN, LOSE; ignored elsewhere. Sets loaded.
- start accepted only in IDLE, WIN, LOSE and only if loaded (or seq_load same cycle; the new data is used). On accept: length 3, index 0, miss_count 0, game_win/game_over 0, go PLAY_ON.
- PLAY_ON: note_out = note[index], note_valid 1 for NOTE_TICKS cycles, then PLAY_OFF.
- PLAY_OFF: note_out 0, note_valid 0 for GAP_TICKS cycles; then, if index == length-1, index 0 and LISTEN, else index+1 and PLAY_ON.
- key_valid ignored in all states except LISTEN.
- LISTEN: timeout counter restarts on entry and on every accepted key. key_code == note[index]: if index == length-1 go PASS, else index+1. Mismatch or counter reaching TIMEOUT_TICKS: go FAIL. key_valid in the expiry cycle wins over timeout.
- PASS (1 cycle): round_pass 1; length 8 → WIN; else length+1, index 0, PLAY_ON.
- FAIL (1 cycle): round_fail 1, miss_count+1; new count == MAX_MISSES → LOSE; else index 0, replay same length via PLAY_ON.
- WIN/LOSE hold until start (restart with stored melody) or reset. miss_count saturates; never wraps.

## Timing
- Cycle 0 = clock edge sampling accepted start. note[0] visible on note_out in cycles 1..NOTE_TICKS.
- Each note slot = NOTE_TICKS+GAP_TICKS cycles. LISTEN entered after L*(NOTE_TICKS+GAP_TICKS) cycles.
- Key sampled at edge k: index_out/state update visible at k+1. The final correct key shows PASS one cycle, then PLAY_ON with note[0] the following cycle.
- round_pass/round_fail high exactly one cycle, coincident with state_out PASS/FAIL.
- Reset asserted mid-operation: outputs reach reset values immediately (async), no pulse emitted. After release, start without a new seq_load is ignored.

## Test plan
- Load 0x87654321, start (NOTE_TICKS=3, GAP_TICKS=1) -> note_out 1,1,1,0,2,2,2,0,3,3,3,0. state_out 3 from cycle 13. length_out 3.
- In LISTEN, keys 1,2,3 -> round_pass pulse, length_out 4, replay 1,2,3,4 with the same slot timing.
- Length 3, keys 1 then 5 -> round_fail pulse, miss_count 1, replay notes 1,2,3 at length 3.
- TIMEOUT_TICKS=20, no keys for three rounds -> fail pulses 20 cycles after each LISTEN entry. After the 3rd: state 7, game_over 1. start -> miss_count 0, length 3, replay.
- Correct keys through length 8 -> state 6, game_win 1. Keys pressed in WIN ignored.
- Reset during PLAY_ON -> note_out 0, state 0. start without seq_load stays IDLE. Key strobes during PLAY_ON/PLAY_OFF leave index_out unchanged.
